// File: rtl/param_shift_reg.sv
// Parametrised universal shift register with an auto-serialise sequencer.
// Start loads Pin and shifts it out MSB-first over WIDTH enabled cycles.
module param_shift_reg #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             En,
   input  logic [2:0]       Mode,
   input  logic             SinLsb,
   input  logic             SinMsb,
   input  logic [WIDTH-1:0] Pin,
   input  logic             Start,
   output logic [WIDTH-1:0] Q,
   output logic             SoutMsb,
   output logic             SoutLsb,
   output logic [CW-1:0]    Count,
   output logic             Busy,
   output logic             Done
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic [CW-1:0]    count_nxt;
   logic             done_nxt;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= IDLE;
         Q     <= '0;
         Count <= '0;
         Done  <= 1'b0;
      end else begin
         state <= state_nxt;
         Q     <= q_nxt;
         Count <= count_nxt;
         Done  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      q_nxt     = Q;
      count_nxt = Count;
      done_nxt  = 1'b0;
      if (En) begin
         unique case (state)
            IDLE: begin
               if (Start) begin
                  q_nxt     = Pin;
                  count_nxt = CW'(WIDTH);
                  state_nxt = RUN;
               end else begin
                  case (Mode)
                     3'b001:  q_nxt = {Q[WIDTH-2:0], SinLsb};
                     3'b010:  q_nxt = {SinMsb, Q[WIDTH-1:1]};
                     3'b011:  q_nxt = {Q[WIDTH-2:0], Q[WIDTH-1]};
                     3'b100:  q_nxt = {Q[0], Q[WIDTH-1:1]};
                     3'b101:  q_nxt = Pin;
                     3'b110:  q_nxt = '0;
                     default: q_nxt = Q;
                  endcase
               end
            end
            RUN: begin
               q_nxt = {Q[WIDTH-2:0], SinLsb};
               // Finishing on Count<=1 keeps Count from ever wrapping below zero.
               if (Count <= CW'(1)) begin
                  count_nxt = '0;
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  count_nxt = Count - CW'(1);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign Busy    = (state == RUN);
   assign SoutMsb = Q[WIDTH-1];
   assign SoutLsb = Q[0];

endmodule

// File: tb/tb_param_shift_reg.sv
// Bench for param_shift_reg: WIDTH=4 and WIDTH=8 instances driven in lockstep
// and compared every cycle against an arithmetic reference model.
module tb_param_shift_reg;

   logic        clk = 1'b0;
   logic        rst_n, en, sin_lsb, sin_msb, start;
   logic [2:0]  mode;
   logic [31:0] pin;

   logic [3:0]  q4;
   logic [2:0]  c4;
   logic        s4m, s4l, b4, d4;
   logic [7:0]  q8;
   logic [3:0]  c8;
   logic        s8m, s8l, b8, d8;

   int errors = 0;
   int checks = 0;

   // Reference model state, index 0 = WIDTH 4, index 1 = WIDTH 8
   int unsigned mw[2] = '{4, 8};
   logic [31:0] mq[2];
   int          mcnt[2];
   bit          mbusy[2];
   bit          mdone[2];

   always #5 clk = ~clk;

   param_shift_reg #(.WIDTH(4)) u4 (
      .Clk(clk), .Rst_n(rst_n), .En(en), .Mode(mode), .SinLsb(sin_lsb),
      .SinMsb(sin_msb), .Pin(pin[3:0]), .Start(start), .Q(q4),
      .SoutMsb(s4m), .SoutLsb(s4l), .Count(c4), .Busy(b4), .Done(d4)
   );

   param_shift_reg #(.WIDTH(8)) u8 (
      .Clk(clk), .Rst_n(rst_n), .En(en), .Mode(mode), .SinLsb(sin_lsb),
      .SinMsb(sin_msb), .Pin(pin[7:0]), .Start(start), .Q(q8),
      .SoutMsb(s8m), .SoutLsb(s8l), .Count(c8), .Busy(b8), .Done(d8)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mreset();
      for (int k = 0; k < 2; k++) begin
         mq[k] = '0; mcnt[k] = 0; mbusy[k] = 0; mdone[k] = 0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int unsigned w = mw[k];
         logic [31:0] m = (32'd1 << w) - 32'd1;
         if (!en) begin
            mdone[k] = 0;
         end else if (mbusy[k]) begin
            mq[k] = ((mq[k] << 1) | 32'(sin_lsb)) & m;
            mcnt[k] = mcnt[k] - 1;
            mdone[k] = (mcnt[k] == 0);
            mbusy[k] = (mcnt[k] != 0);
         end else begin
            mdone[k] = 0;
            if (start) begin
               mq[k] = pin & m; mcnt[k] = int'(w); mbusy[k] = 1;
            end else begin
               case (mode)
                  3'b001: mq[k] = ((mq[k] << 1) | 32'(sin_lsb)) & m;
                  3'b010: mq[k] = (mq[k] >> 1) | (32'(sin_msb) << (w - 1));
                  3'b011: mq[k] = ((mq[k] << 1) | (mq[k] >> (w - 1))) & m;
                  3'b100: mq[k] = (mq[k] >> 1) | ((mq[k] & 32'd1) << (w - 1));
                  3'b101: mq[k] = pin & m;
                  3'b110: mq[k] = '0;
                  default: ;
               endcase
            end
         end
      end
   endtask

   task automatic check_all();
      check("q4",    {28'd0, q4}, mq[0]);
      check("cnt4",  {29'd0, c4}, 32'(mcnt[0]));
      check("busy4", {31'd0, b4}, 32'(mbusy[0]));
      check("done4", {31'd0, d4}, 32'(mdone[0]));
      check("smsb4", {31'd0, s4m}, (mq[0] >> 3) & 32'd1);
      check("slsb4", {31'd0, s4l}, mq[0] & 32'd1);
      check("q8",    {24'd0, q8}, mq[1]);
      check("cnt8",  {28'd0, c8}, 32'(mcnt[1]));
      check("busy8", {31'd0, b8}, 32'(mbusy[1]));
      check("done8", {31'd0, d8}, 32'(mdone[1]));
      check("smsb8", {31'd0, s8m}, (mq[1] >> 7) & 32'd1);
      check("slsb8", {31'd0, s8l}, mq[1] & 32'd1);
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) mreset();
      else model_step();
      #1 check_all();
   endtask

   // Called just after a tick: asserts reset between edges and releases it before the next
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1 mreset();
      check_all();
      check("areset_q8", {24'd0, q8}, 32'd0);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] a5;
      logic [7:0] p;
      logic [7:0] got;
      bit         seen;
      int         n;
      rst_n = 1'b0; en = 1'b1; mode = 3'b000; sin_lsb = 1'b0; sin_msb = 1'b0;
      start = 1'b0; pin = '0;
      mreset();
      #12 check_all();
      rst_n = 1'b1;

      // Parallel load then asynchronous reset with no edge
      mode = 3'b101; pin = 32'hB;
      tick();
      check("load_q4", {28'd0, q4}, 32'hB);
      async_reset();
      check("areset_q4", {28'd0, q4}, 32'h0);

      // Shift-up stream 1,0,1,1
      mode = 3'b001;
      sin_lsb = 1'b1; tick(); check("su1", {28'd0, q4}, 32'h1);
      sin_lsb = 1'b0; tick(); check("su2", {28'd0, q4}, 32'h2);
      sin_lsb = 1'b1; tick(); check("su3", {28'd0, q4}, 32'h5);
      sin_lsb = 1'b1; tick(); check("su4", {28'd0, q4}, 32'hB);
      check("su_sout", {31'd0, s4m}, 32'd1);

      // Shift-down, rotate-up twice, rotate-down
      mode = 3'b010; sin_msb = 1'b0; tick(); check("sd", {28'd0, q4}, 32'h5);
      mode = 3'b011; tick(); check("ru1", {28'd0, q4}, 32'hA);
      tick(); check("ru2", {28'd0, q4}, 32'h5);
      mode = 3'b100; tick(); check("rd", {28'd0, q4}, 32'hA);

      // Auto-serialise 8'hA5
      mode = 3'b000; sin_lsb = 1'b0; pin = 32'hA5; start = 1'b1;
      tick();
      start = 1'b0;
      a5 = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         check("auto_busy", {31'd0, b8}, 32'd1);
         check("auto_cnt",  {28'd0, c8}, 32'(8 - i));
         check("auto_sout", {31'd0, s8m}, {31'd0, a5[7 - i]});
         check("auto_nodone", {31'd0, d8}, 32'd0);
         tick();
      end
      check("auto_done", {31'd0, d8}, 32'd1);
      check("auto_qend", {24'd0, q8}, 32'd0);
      tick();
      check("auto_pulse", {31'd0, d8}, 32'd0);

      // Stall with En low for 3 cycles while Mode/Start toggle
      p = 8'($urandom); pin = {24'd0, p}; start = 1'b1;
      tick();
      start = 1'b0; got = '0; seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         en = !(c >= 3 && c <= 5);
         if (!en) begin mode = 3'($urandom); start = ~start; end
         else start = 1'b0;
         if (b8 && en) got = {got[6:0], s8m};
         tick();
         seen = d8;
      end
      en = 1'b1; start = 1'b0; mode = 3'b000;
      check("stall_done_seen", {31'd0, seen}, 32'd1);
      check("stall_stream", {24'd0, got}, {24'd0, p});

      // Back-to-back with Start held; second word 8'h3C
      pin = 32'($urandom); start = 1'b1;
      tick();
      pin = 32'h3C; seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         tick();
         seen = d8;
      end
      check("b2b_done1", {31'd0, seen}, 32'd1);
      tick();
      start = 1'b0;
      check("b2b_busy2", {31'd0, b8}, 32'd1);
      got = '0;
      for (int i = 0; i < 8; i++) begin
         got = {got[6:0], s8m};
         tick();
      end
      check("b2b_stream", {24'd0, got}, 32'h3C);
      check("b2b_done2", {31'd0, d8}, 32'd1);

      // Reset mid-sequence aborts without Done
      pin = 32'($urandom); start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      async_reset();
      check("abort_busy", {31'd0, b8}, 32'd0);
      check("abort_cnt",  {28'd0, c8}, 32'd0);
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         seen = seen | d8 | d4;
      end
      check("abort_nodone", {31'd0, seen}, 32'd0);

      // Randomised traffic
      n = 0;
      for (int c = 0; c < 400; c++) begin
         en      = ($urandom_range(0, 3) != 0);
         mode    = 3'($urandom);
         start   = ($urandom_range(0, 7) == 0);
         sin_lsb = 1'($urandom);
         sin_msb = 1'($urandom);
         pin     = $urandom;
         tick();
         if ($urandom_range(0, 99) == 0) begin
            async_reset();
            n++;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
